// File: rtl/arm_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle ARM controller and its datapath.
// The controller drives the master side; the datapath owns the slave side.
interface arm_multicycle_ctrl_if #(
  parameter int unsigned STATE_W = 4
);
  logic [31:12]       Instr;
  logic [3:0]         ALUFlags;
  logic               PCWrite;
  logic               AdrSrc;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic [1:0]         ResultSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [2:0]         ALUControl;
  logic [1:0]         ImmSrc;
  logic [1:0]         RegSrc;
  logic [STATE_W-1:0] dbg_state;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, dbg_state
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, dbg_state
  );
endinterface

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control unit: FETCH/DECODE/EXEC/MEM/WB sequencer, NZCV flags and
// condition check. Control outputs are combinational from state and the stable IR fields.
module arm_multicycle_ctrl #(
  parameter int unsigned STATE_W = 4
) (
  input logic                  clk,
  input logic                  reset,
  arm_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_e;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOrr = 3'b011;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = bus.Instr[31:28];
  assign op        = bus.Instr[27:26];
  assign funct     = bus.Instr[25:20];
  assign rd        = bus.Instr[15:12];
  assign unused_rn = ^bus.Instr[19:16];

  function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0:    cond_check = z;
      4'h1:    cond_check = ~z;
      4'h2:    cond_check = cy;
      4'h3:    cond_check = ~cy;
      4'h4:    cond_check = n;
      4'h5:    cond_check = ~n;
      4'h6:    cond_check = v;
      4'h7:    cond_check = ~v;
      4'h8:    cond_check = cy & ~z;
      4'h9:    cond_check = ~cy | z;
      4'hA:    cond_check = (n == v);
      4'hB:    cond_check = (n != v);
      4'hC:    cond_check = ~z & (n == v);
      4'hD:    cond_check = z | (n != v);
      4'hE:    cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

  // Data-processing command decode; unlisted commands execute as a silent ADD.
  logic [2:0] dp_ctl;
  logic       dp_valid;
  logic       dp_all_flags;
  logic       dp_wb;

  always_comb begin
    dp_ctl       = AluAdd;
    dp_valid     = 1'b1;
    dp_all_flags = 1'b1;
    dp_wb        = 1'b1;
    case (funct[4:1])
      4'b0100: dp_ctl = AluAdd;
      4'b0010: dp_ctl = AluSub;
      4'b0000: begin
        dp_ctl       = AluAnd;
        dp_all_flags = 1'b0;
      end
      4'b1100: begin
        dp_ctl       = AluOrr;
        dp_all_flags = 1'b0;
      end
      4'b1010: begin
        dp_ctl = AluSub;
        dp_wb  = 1'b0;
      end
      default: begin
        dp_valid = 1'b0;
        dp_wb    = 1'b0;
      end
    endcase
  end

  logic       pc_write, mem_write, ir_write, reg_write, adr_src, reg_src0;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control;

  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    cond_ex_d   = cond_ex_q;
    pc_write    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    adr_src     = 1'b0;
    reg_src0    = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = AluAdd;

    unique case (state_q)
      StFetch: begin
        ir_write   = 1'b1;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
        state_d    = StDecode;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        cond_ex_d = cond_check(cond, flags_q);
        case (op)
          2'b01:   state_d = StMemAdr;
          2'b00:   state_d = funct[5] ? StExecI : StExecR;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        alu_src_b = 2'b01;
        state_d   = funct[0] ? StMemRd : StMemWr;
      end
      StMemRd: begin
        adr_src = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = cond_ex_q;
        state_d    = StFetch;
      end
      StMemWr: begin
        adr_src   = 1'b1;
        mem_write = cond_ex_q;
        state_d   = StFetch;
      end
      StExecR, StExecI: begin
        alu_src_b   = (state_q == StExecI) ? 2'b01 : 2'b00;
        alu_control = dp_ctl;
        // Logical ops only define N and Z; C and V keep their previous values.
        if (funct[0] && cond_ex_q && dp_valid) begin
          flags_d = dp_all_flags ? bus.ALUFlags : {bus.ALUFlags[3:2], flags_q[1:0]};
        end
        state_d = dp_wb ? StAluWb : StFetch;
      end
      StAluWb: begin
        if (rd == 4'hF) pc_write = cond_ex_q;
        else            reg_write = cond_ex_q;
        state_d = StFetch;
      end
      StBranch: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = cond_ex_q;
        reg_src0   = 1'b1;
        state_d    = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  // Write enables are gated by reset directly so an in-flight write dies immediately.
  assign bus.PCWrite    = pc_write & reset;
  assign bus.IRWrite    = ir_write & reset;
  assign bus.RegWrite   = reg_write & reset;
  assign bus.MemWrite   = mem_write & reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {(op == 2'b01) && !funct[0], reg_src0};
  assign bus.dbg_state  = STATE_W'(state_q);

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Directed bench for arm_multicycle_ctrl: per-cycle state and write-enable checks for each
// instruction class, flag/condition interplay, and asynchronous reset mid-store.
module tb_arm_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset;

  arm_multicycle_ctrl_if #(.STATE_W(4)) bus ();

  arm_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [1:0] o_res   [8];
  logic [1:0] o_srca  [8];
  logic [1:0] o_srcb  [8];
  logic [2:0] o_aluctl[8];
  logic [1:0] o_regsrc[8];
  logic [1:0] o_imm   [8];
  logic       o_adr   [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] we_now();
    return {bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.IRWrite};
  endfunction

  // Called at a FETCH sample point; st/we hold one nibble per cycle, first cycle leftmost.
  // we nibble = {PCWrite, RegWrite, MemWrite, IRWrite}. Returns at the next FETCH sample point.
  task automatic run(input string name, input logic [19:0] ins, input logic [3:0] af,
                     input int n, input logic [19:0] st, input logic [19:0] we);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      bus.Instr    = ins;
      bus.ALUFlags = af;
      #1;
      chk($sformatf("%s c%0d state", name, i), 32'(bus.dbg_state), 32'(st[19-4*i -: 4]));
      chk($sformatf("%s c%0d we", name, i), 32'(we_now()), 32'(we[19-4*i -: 4]));
      o_res[i]    = bus.ResultSrc;
      o_srca[i]   = bus.ALUSrcA;
      o_srcb[i]   = bus.ALUSrcB;
      o_aluctl[i] = bus.ALUControl;
      o_regsrc[i] = bus.RegSrc;
      o_imm[i]    = bus.ImmSrc;
      o_adr[i]    = bus.AdrSrc;
    end
    @(negedge clk);
  endtask

  initial begin
    reset        = 1'b0;
    bus.Instr    = 20'h00000;
    bus.ALUFlags = 4'b0000;
    #2;
    chk("rst state", 32'(bus.dbg_state), 32'd0);
    chk("rst we", 32'(we_now()), 32'h0);
    chk("rst ResultSrc", 32'(bus.ResultSrc), 32'b10);
    chk("rst ALUSrcB", 32'(bus.ALUSrcB), 32'b10);
    @(negedge clk);
    reset = 1'b1;

    run("ADDI", 20'hE2821, 4'h0, 4, 20'h01780, 20'h90040);
    chk("fetch SrcA", 32'(o_srca[0]), 32'b01);
    chk("fetch SrcB", 32'(o_srcb[0]), 32'b10);
    chk("fetch Res", 32'(o_res[0]), 32'b10);
    chk("addi ctl", 32'(o_aluctl[2]), 32'b000);
    chk("addi SrcB", 32'(o_srcb[2]), 32'b01);
    chk("addi SrcA", 32'(o_srca[2]), 32'b00);
    chk("aluwb Res", 32'(o_res[3]), 32'b00);

    run("LDR", 20'hE5910, 4'h0, 5, 20'h01234, 20'h90004);
    chk("ldr memadr SrcB", 32'(o_srcb[2]), 32'b01);
    chk("ldr memrd Adr", 32'(o_adr[3]), 32'd1);
    chk("ldr memwb Res", 32'(o_res[4]), 32'b01);
    chk("ldr ImmSrc", 32'(o_imm[1]), 32'b01);

    run("STR", 20'hE5810, 4'h0, 4, 20'h01250, 20'h90020);
    chk("str RegSrc", 32'(o_regsrc[3]), 32'b10);
    chk("str memwr Adr", 32'(o_adr[3]), 32'd1);

    run("SUBS z", 20'hE0500, 4'b0100, 4, 20'h01680, 20'h90040);
    chk("subs ctl", 32'(o_aluctl[2]), 32'b001);
    chk("subs SrcB", 32'(o_srcb[2]), 32'b00);

    run("BEQ t", 20'h0A000, 4'h0, 3, 20'h01900, 20'h90800);
    chk("b RegSrc", 32'(o_regsrc[2]), 32'b01);
    chk("b SrcA", 32'(o_srca[2]), 32'b10);
    chk("b Res", 32'(o_res[2]), 32'b10);
    chk("b ImmSrc", 32'(o_imm[2]), 32'b10);
    run("BNE nt", 20'h1A000, 4'h0, 3, 20'h01900, 20'h90000);
    run("ADDNE nt", 20'h12821, 4'h0, 4, 20'h01780, 20'h90000);

    // Flags 0011, then ANDS with ALUFlags 1011 -> 1011
    run("SUBS cv", 20'hE0500, 4'b0011, 4, 20'h01680, 20'h90040);
    run("ANDS 1", 20'hE0110, 4'b1011, 4, 20'h01680, 20'h90040);
    chk("ands ctl", 32'(o_aluctl[2]), 32'b010);
    run("BGE t", 20'hAA000, 4'h0, 3, 20'h01900, 20'h90800);
    run("BHI t", 20'h8A000, 4'h0, 3, 20'h01900, 20'h90800);
    run("BLT nt", 20'hBA000, 4'h0, 3, 20'h01900, 20'h90000);

    // ANDS with ALUFlags 0100 after 1011 -> N=0 Z=1, C V held -> 0111
    run("ANDS 2", 20'hE0110, 4'b0100, 4, 20'h01680, 20'h90040);
    run("BVS t", 20'h6A000, 4'h0, 3, 20'h01900, 20'h90800);
    run("BCS t", 20'h2A000, 4'h0, 3, 20'h01900, 20'h90800);
    run("BMI nt", 20'h4A000, 4'h0, 3, 20'h01900, 20'h90000);
    run("BEQ t2", 20'h0A000, 4'h0, 3, 20'h01900, 20'h90800);

    // Unlisted cmd (EOR) with S=1: no flag update, no writeback
    run("EORS", 20'hE0300, 4'b1000, 3, 20'h01600, 20'h90000);
    run("BMI nt2", 20'h4A000, 4'h0, 3, 20'h01900, 20'h90000);

    run("CMP", 20'hE1500, 4'b1000, 3, 20'h01600, 20'h90000);
    chk("cmp ctl", 32'(o_aluctl[2]), 32'b001);
    run("BMI t", 20'h4A000, 4'h0, 3, 20'h01900, 20'h90800);
    run("BEQ nt", 20'h0A000, 4'h0, 3, 20'h01900, 20'h90000);

    run("ORR", 20'hE1810, 4'h0, 4, 20'h01680, 20'h90040);
    chk("orr ctl", 32'(o_aluctl[2]), 32'b011);

    run("LDREQ nt", 20'h05910, 4'h0, 5, 20'h01234, 20'h90000);
    run("STREQ nt", 20'h05810, 4'h0, 4, 20'h01250, 20'h90000);
    run("ADD PC", 20'hE28FF, 4'h0, 4, 20'h01780, 20'h90080);
    run("NV", 20'hF2821, 4'h0, 4, 20'h01780, 20'h90000);
    run("OP11", 20'hEC000, 4'h0, 2, 20'h01000, 20'h90000);

    // Asynchronous reset in the middle of MEMWR
    bus.Instr = 20'hE5810;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("memwr state", 32'(bus.dbg_state), 32'd5);
    chk("memwr MemWrite", 32'(bus.MemWrite), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst MemWrite", 32'(bus.MemWrite), 32'd0);
    chk("arst state", 32'(bus.dbg_state), 32'd0);
    chk("arst PCWrite", 32'(bus.PCWrite), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post rst state", 32'(bus.dbg_state), 32'd0);
    chk("post rst PCWrite", 32'(bus.PCWrite), 32'd1);
    chk("post rst IRWrite", 32'(bus.IRWrite), 32'd1);

    run("ADDI 2", 20'hE2821, 4'h0, 4, 20'h01780, 20'h90040);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
